// File: rtl/mrna_iso_chain_seq.sv
// rtl/mrna_iso_chain_seq.sv - protocol sequencer for a chain of mRNA-isolation units
// Walks load/lyse/mix/bead/sep/wash/collect phases; all valve outputs are registered, 1 = closed.
module mrna_iso_chain_seq #(
   parameter int N_UNITS   = 2,
   parameter int CW        = 16,
   parameter int LOAD_CYC  = 64,
   parameter int LYSE_CYC  = 128,
   parameter int PUMP_DIV  = 8,
   parameter int MIX_STEPS = 96,
   parameter int BEAD_CYC  = 64,
   parameter int SEP_CYC   = 128,
   parameter int COLL_CYC  = 32,
   parameter int FLUSH_CYC = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [N_UNITS-1:0] unit_en,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [3:0]         phase,
   output logic [3:0]         cur_unit,
   output logic [N_UNITS-1:0] cells_in_ctl,
   output logic [N_UNITS-1:0] collect_ctl,
   output logic               cells_out_ctl,
   output logic               lysis_in_ctl,
   output logic               lysis_waste_ctl,
   output logic               beads_in_ctl,
   output logic               bead_waste_ctl,
   output logic               push_ctl,
   output logic               sep_ctl,
   output logic               sieve_ctl,
   output logic               waste_ctl,
   output logic [2:0]         pump
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0, S_LOAD = 4'd1, S_LYSE = 4'd2, S_MIX = 4'd3, S_BEAD = 4'd4,
      S_SEP = 4'd5, S_WASH = 4'd6, S_COLLECT = 4'd7, S_DONE = 4'd8, S_FLUSH = 4'd9
   } state_t;

   state_t             state, nstate;
   logic [CW-1:0]      timer, ntimer;
   logic [CW-1:0]      step, nstep;
   logic [3:0]         unit, nunit;
   logic [N_UNITS-1:0] mask, nmask;
   logic [1:0]         pidx, npidx;
   logic [4:0]         load_hit, first_hit, next_hit;

   // Returns {found, index} of the lowest enabled unit at or above 'from'.
   function automatic logic [4:0] find_en(input logic [N_UNITS-1:0] m, input logic [4:0] from);
      logic [4:0] r;
      r = '0;
      for (int i = N_UNITS - 1; i >= 0; i--)
         if (m[i] && 5'(i) >= from) r = {1'b1, 4'(i)};
      return r;
   endfunction

   function automatic logic [2:0] pump_pat(input logic [1:0] idx);
      case (idx)
         2'd0:    return 3'b110;
         2'd1:    return 3'b101;
         default: return 3'b011;
      endcase
   endfunction

   always_comb begin
      load_hit  = find_en(unit_en, 5'd0);
      first_hit = find_en(mask, 5'd0);
      next_hit  = find_en(mask, {1'b0, unit} + 5'd1);
      nstate = state;
      nunit  = unit;
      nmask  = mask;
      nstep  = step;
      npidx  = pidx;
      ntimer = (timer == '0) ? '0 : timer - CW'(1);
      case (state)
         S_IDLE: if (start && |unit_en) begin
            nstate = S_LOAD;
            nmask  = unit_en;
            nunit  = load_hit[3:0];
            ntimer = CW'(LOAD_CYC - 1);
         end
         S_LOAD: if (timer == '0) begin
            if (next_hit[4]) begin
               nunit  = next_hit[3:0];
               ntimer = CW'(LOAD_CYC - 1);
            end else begin
               nstate = S_LYSE;
               nunit  = '0;
               ntimer = CW'(LYSE_CYC - 1);
            end
         end
         S_LYSE: if (timer == '0) begin
            nstate = S_MIX;
            nstep  = '0;
            npidx  = '0;
            ntimer = CW'(PUMP_DIV - 1);
         end
         S_MIX: if (timer == '0) begin
            if (step == CW'(MIX_STEPS - 1)) begin
               nstate = S_BEAD;
               ntimer = CW'(BEAD_CYC - 1);
            end else begin
               nstep  = step + CW'(1);
               npidx  = (pidx == 2'd2) ? 2'd0 : pidx + 2'd1;
               ntimer = CW'(PUMP_DIV - 1);
            end
         end
         S_BEAD: if (timer == '0) begin
            nstate = S_SEP;
            ntimer = CW'(SEP_CYC - 1);
         end
         S_SEP: if (timer == '0) begin
            nstate = S_WASH;
            ntimer = CW'(SEP_CYC - 1);
         end
         S_WASH: if (timer == '0) begin
            nstate = S_COLLECT;
            nunit  = first_hit[3:0];
            ntimer = CW'(COLL_CYC - 1);
         end
         S_COLLECT: if (timer == '0) begin
            if (next_hit[4]) begin
               nunit  = next_hit[3:0];
               ntimer = CW'(COLL_CYC - 1);
            end else begin
               nstate = S_DONE;
               nunit  = '0;
            end
         end
         S_DONE:  nstate = S_IDLE;
         S_FLUSH: if (timer == '0) nstate = S_IDLE;
         default: nstate = S_IDLE;
      endcase
      // Abort overrides any phase-end transition computed above.
      if (abort && state != S_IDLE && state != S_FLUSH) begin
         nstate = S_FLUSH;
         nunit  = '0;
         ntimer = CW'(FLUSH_CYC - 1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         timer           <= '0;
         step            <= '0;
         unit            <= '0;
         mask            <= '0;
         pidx            <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         aborted         <= 1'b0;
         phase           <= 4'd0;
         cur_unit        <= 4'd0;
         cells_in_ctl    <= '1;
         collect_ctl     <= '1;
         cells_out_ctl   <= 1'b1;
         lysis_in_ctl    <= 1'b1;
         lysis_waste_ctl <= 1'b1;
         beads_in_ctl    <= 1'b1;
         bead_waste_ctl  <= 1'b1;
         push_ctl        <= 1'b1;
         sep_ctl         <= 1'b1;
         sieve_ctl       <= 1'b1;
         waste_ctl       <= 1'b1;
         pump            <= 3'b111;
      end else begin
         state           <= nstate;
         timer           <= ntimer;
         step            <= nstep;
         unit            <= nunit;
         mask            <= nmask;
         pidx            <= npidx;
         // Outputs decode the next state so they line up with the state register.
         busy            <= (nstate != S_IDLE);
         done            <= (nstate == S_DONE);
         aborted         <= (nstate == S_FLUSH) && (state != S_FLUSH);
         phase           <= nstate;
         cur_unit        <= (nstate == S_LOAD || nstate == S_COLLECT) ? nunit : 4'd0;
         cells_in_ctl    <= (nstate == S_LOAD) ? ~(N_UNITS'(1) << nunit) : '1;
         collect_ctl     <= (nstate == S_COLLECT) ? ~(N_UNITS'(1) << nunit) : '1;
         cells_out_ctl   <= (nstate != S_LOAD);
         lysis_in_ctl    <= (nstate != S_LYSE);
         lysis_waste_ctl <= (nstate != S_LYSE);
         beads_in_ctl    <= (nstate != S_BEAD);
         bead_waste_ctl  <= (nstate != S_BEAD);
         push_ctl        <= !(nstate == S_WASH || nstate == S_COLLECT);
         sep_ctl         <= (nstate != S_SEP);
         sieve_ctl       <= 1'b1;
         waste_ctl       <= !(nstate == S_WASH || nstate == S_FLUSH);
         pump            <= (nstate == S_MIX) ? pump_pat(npidx) : 3'b111;
      end
   end

endmodule

// File: tb/tb_mrna_iso_chain_seq.sv
// tb/tb_mrna_iso_chain_seq.sv - scoreboard bench for mrna_iso_chain_seq
// Expected output segments (snapshot + run length) are queued per run and compared as the DUT changes.
module tb_mrna_iso_chain_seq;

   localparam int NU = 2;
   localparam int LOAD_L = 64, LYSE_L = 128, DIV = 8, STEPS = 96, BEAD_L = 64;
   localparam int SEP_L = 128, COLL_L = 32, FLUSH_L = 16;

   logic clk = 1'b0;
   logic rst_n, start, abort;
   logic [NU-1:0] unit_en;
   logic busy, done, aborted;
   logic [3:0] phase, cur_unit;
   logic [NU-1:0] cells_in_ctl, collect_ctl;
   logic cells_out_ctl, lysis_in_ctl, lysis_waste_ctl, beads_in_ctl, bead_waste_ctl;
   logic push_ctl, sep_ctl, sieve_ctl, waste_ctl;
   logic [2:0] pump;

   always #5 clk = ~clk;

   mrna_iso_chain_seq #(
      .N_UNITS(NU), .CW(16), .LOAD_CYC(LOAD_L), .LYSE_CYC(LYSE_L), .PUMP_DIV(DIV),
      .MIX_STEPS(STEPS), .BEAD_CYC(BEAD_L), .SEP_CYC(SEP_L), .COLL_CYC(COLL_L), .FLUSH_CYC(FLUSH_L)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .unit_en(unit_en),
      .busy(busy), .done(done), .aborted(aborted), .phase(phase), .cur_unit(cur_unit),
      .cells_in_ctl(cells_in_ctl), .collect_ctl(collect_ctl), .cells_out_ctl(cells_out_ctl),
      .lysis_in_ctl(lysis_in_ctl), .lysis_waste_ctl(lysis_waste_ctl), .beads_in_ctl(beads_in_ctl),
      .bead_waste_ctl(bead_waste_ctl), .push_ctl(push_ctl), .sep_ctl(sep_ctl),
      .sieve_ctl(sieve_ctl), .waste_ctl(waste_ctl), .pump(pump)
   );

   typedef struct packed {
      logic [3:0] phase;
      logic [3:0] unit;
      logic [NU-1:0] cin;
      logic [NU-1:0] col;
      logic cout, lin, lwa, bin, bwa, push, sep, sieve, waste;
      logic [2:0] pump;
      logic busy, done, aborted;
   } snap_t;

   typedef struct {
      snap_t s;
      int    len;   // 0 = length not checked (idle gaps)
   } seg_t;

   seg_t  exp_q[$];
   int    vectors = 0;
   int    miscompares = 0;
   bit    mon_on = 0;
   bit    have = 0;
   snap_t cur;
   int    cur_len = 0;
   int    seg_no = 0;

   function automatic snap_t quiet(input logic b);
      snap_t s;
      s = '1;
      s.phase = 4'd0; s.unit = 4'd0;
      s.busy = b; s.done = 1'b0; s.aborted = 1'b0;
      return s;
   endfunction

   function automatic snap_t sample();
      snap_t s;
      s = '{phase, cur_unit, cells_in_ctl, collect_ctl, cells_out_ctl, lysis_in_ctl,
            lysis_waste_ctl, beads_in_ctl, bead_waste_ctl, push_ctl, sep_ctl, sieve_ctl,
            waste_ctl, pump, busy, done, aborted};
      return s;
   endfunction

   function automatic int run_total(input logic [NU-1:0] m);
      int n = 0;
      for (int u = 0; u < NU; u++) if (m[u]) n++;
      return n * (LOAD_L + COLL_L) + LYSE_L + STEPS * DIV + BEAD_L + 2 * SEP_L;
   endfunction

   // kind: 0 full run, 1 abort sampled on run cycle 'cut', 2 reset sampled on run cycle 'cut'
   task automatic build_run(input logic [NU-1:0] m, input int kind, input int cut);
      seg_t run[$];
      seg_t g;
      snap_t s;
      logic [2:0] pats[3];
      int acc, limit;
      pats[0] = 3'b110; pats[1] = 3'b101; pats[2] = 3'b011;
      s = quiet(1'b1);
      for (int u = 0; u < NU; u++) if (m[u]) begin
         g.s = s; g.s.phase = 4'd1; g.s.unit = 4'(u); g.s.cin = ~(NU'(1) << u); g.s.cout = 1'b0;
         g.len = LOAD_L; run.push_back(g);
      end
      g.s = s; g.s.phase = 4'd2; g.s.lin = 1'b0; g.s.lwa = 1'b0; g.len = LYSE_L; run.push_back(g);
      for (int k = 0; k < STEPS; k++) begin
         g.s = s; g.s.phase = 4'd3; g.s.pump = pats[k % 3]; g.len = DIV; run.push_back(g);
      end
      g.s = s; g.s.phase = 4'd4; g.s.bin = 1'b0; g.s.bwa = 1'b0; g.len = BEAD_L; run.push_back(g);
      g.s = s; g.s.phase = 4'd5; g.s.sep = 1'b0; g.len = SEP_L; run.push_back(g);
      g.s = s; g.s.phase = 4'd6; g.s.push = 1'b0; g.s.waste = 1'b0; g.len = SEP_L; run.push_back(g);
      for (int u = 0; u < NU; u++) if (m[u]) begin
         g.s = s; g.s.phase = 4'd7; g.s.unit = 4'(u); g.s.col = ~(NU'(1) << u); g.s.push = 1'b0;
         g.len = COLL_L; run.push_back(g);
      end
      g.s = s; g.s.phase = 4'd8; g.s.done = 1'b1; g.len = 1; run.push_back(g);
      limit = (kind == 0) ? 32'h7fff_ffff : cut;
      acc = 0;
      foreach (run[i]) if (acc < limit) begin
         g = run[i];
         if (g.len > limit - acc) g.len = limit - acc;
         exp_q.push_back(g);
         acc += g.len;
      end
      if (kind == 1) begin
         g.s = s; g.s.phase = 4'd9; g.s.waste = 1'b0; g.s.aborted = 1'b1; g.len = 1; exp_q.push_back(g);
         g.s.aborted = 1'b0; g.len = FLUSH_L - 1; exp_q.push_back(g);
      end
      g.s = quiet(1'b0); g.len = 0; exp_q.push_back(g);
   endtask

   task automatic close_seg();
      seg_t g;
      vectors++;
      seg_no++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL seg#%0d unexpected: got snap=%h len=%0d, want none", seg_no, cur, cur_len);
      end else begin
         g = exp_q.pop_front();
         if (g.s !== cur || (g.len != 0 && g.len != cur_len)) begin
            miscompares++;
            $display("FAIL seg#%0d phase%0d: got snap=%h len=%0d, want snap=%h len=%0d",
                     seg_no, g.s.phase, cur, cur_len, g.s, g.len);
         end
      end
   endtask

   initial begin
      snap_t s;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            s = sample();
            if (!have) begin
               cur = s; cur_len = 1; have = 1;
            end else if (s === cur) begin
               cur_len++;
            end else begin
               close_seg();
               cur = s; cur_len = 1;
            end
         end
      end
   end

   task automatic run_one(input logic [NU-1:0] m, input int kind, input int cut);
      int t;
      @(negedge clk);
      build_run(m, kind, cut);
      start = 1'b1; unit_en = m;
      @(negedge clk);
      start = 1'b0; unit_en = NU'($urandom);
      if (kind == 1) begin
         repeat (cut - 1) @(negedge clk);
         abort = 1'b1;
         repeat (3) @(negedge clk);
         abort = 1'b0;
      end else if (kind == 2) begin
         repeat (cut - 1) @(negedge clk);
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
      end else begin
         repeat (200) @(negedge clk);
         start = 1'b1; unit_en = NU'($urandom);
         @(negedge clk);
         start = 1'b0;
      end
      t = 0;
      while (busy !== 1'b0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL run_timeout: busy=%b after %0d cycles, want 0", busy, t);
      end
      repeat (5) @(negedge clk);
   endtask

   initial begin
      seg_t g;
      logic [NU-1:0] m;
      int kind, cut;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; unit_en = '0;
      g.s = quiet(1'b0); g.len = 0; exp_q.push_back(g);
      @(negedge clk);
      @(negedge clk);
      mon_on = 1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      run_one(2'b11, 0, 0);
      run_one(2'b10, 0, 0);
      @(negedge clk);
      start = 1'b1; unit_en = '0;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      run_one(2'b11, 1, LOAD_L * 2 + 11);
      run_one(2'b11, 2, LOAD_L * 2 + LYSE_L + STEPS * DIV + BEAD_L + 50);
      run_one(2'b01, 1, 1);
      run_one(2'b10, 1, run_total(2'b10) + 1);
      for (int r = 0; r < 6; r++) begin
         m = NU'($urandom_range(1, 3));
         kind = $urandom_range(0, 2);
         cut = (kind == 1) ? $urandom_range(1, run_total(m) + 1) : $urandom_range(1, run_total(m));
         run_one(m, kind, cut);
      end

      repeat (3) @(negedge clk);
      mon_on = 0;
      #1;
      vectors++;
      if (exp_q.size() != 1) begin
         miscompares++;
         $display("FAIL queue_drain: got %0d pending segments, want 1", exp_q.size());
      end else begin
         close_seg();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
